// File: rtl/maj_seq_pkg.sv
// Shared types and constants for the majority-network truth-table sequencer.
// Each program node selects three operands that feed a single MAJ3 gate.
package maj_seq_pkg;

   localparam int NODES    = 8;
   localparam int WORD_W   = 32;
   localparam int PATTERNS = 128;

   localparam logic [3:0] SEL_X0        = 4'd0;
   localparam logic [3:0] SEL_X1        = 4'd1;
   localparam logic [3:0] SEL_X2        = 4'd2;
   localparam logic [3:0] SEL_X3        = 4'd3;
   localparam logic [3:0] SEL_X4        = 4'd4;
   localparam logic [3:0] SEL_X5        = 4'd5;
   localparam logic [3:0] SEL_X6        = 4'd6;
   localparam logic [3:0] SEL_ZERO      = 4'd7;
   localparam logic [3:0] SEL_NODE_BASE = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_EMIT
   } state_e;

   typedef struct packed {
      logic [3:0] selC;
      logic [3:0] selB;
      logic [3:0] selA;
   } node_cfg_t;

   localparam node_cfg_t NODE_RESET = '{selC: SEL_ZERO, selB: SEL_ZERO, selA: SEL_ZERO};

   // A node may only read nodes evaluated earlier in the current pattern.
   function automatic logic selectOperand(input logic [3:0] sel,
                                          input logic [6:0] pat,
                                          input logic [7:0] vals,
                                          input logic [2:0] cur);
      logic bitVal;
      bitVal = 1'b0;
      if (sel < SEL_ZERO) begin
         bitVal = pat[sel[2:0]];
      end else if (sel >= SEL_NODE_BASE && sel[2:0] < cur) begin
         bitVal = vals[sel[2:0]];
      end
      return bitVal;
   endfunction

endpackage

// File: rtl/maj3_cell.sv
// Three-input majority gate, the only arithmetic element of the sequencer.
module maj3_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic y_o
);

   assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/maj_net_sequencer.sv
// Sweeps all 128 input patterns through a programmable MAJ3 network, one node
// per cycle, and streams the resulting truth table as four 32-bit words.
module maj_net_sequencer
   import maj_seq_pkg::*;
#(
   parameter int NODES = maj_seq_pkg::NODES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_addr,
   input  logic [11:0]         cfg_data,
   input  logic                len_we,
   input  logic [2:0]          len_data,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                tt_valid,
   input  logic                tt_ready,
   output logic [WORD_W-1:0]   tt_data,
   output logic [1:0]          tt_idx
);

   localparam int PAT_W = $clog2(PATTERNS);

   state_e                  state_q, state_d;
   node_cfg_t [NODES-1:0]   prog_q, prog_d;
   logic [2:0]              len_q, len_d;
   logic [2:0]              node_q, node_d;
   logic [PAT_W-1:0]        pat_q, pat_d;
   logic [NODES-1:0]        nodeVal_q, nodeVal_d;
   logic [WORD_W-1:0]       ttData_q, ttData_d;
   logic [1:0]              ttIdx_q, ttIdx_d;
   logic                    done_q, done_d;

   node_cfg_t curCfg;
   logic      opA, opB, opC, majOut;

   assign curCfg = prog_q[node_q];
   assign opA    = selectOperand(curCfg.selA, pat_q, nodeVal_q, node_q);
   assign opB    = selectOperand(curCfg.selB, pat_q, nodeVal_q, node_q);
   assign opC    = selectOperand(curCfg.selC, pat_q, nodeVal_q, node_q);

   maj3_cell u_maj3 (
      .a_i (opA),
      .b_i (opB),
      .c_i (opC),
      .y_o (majOut)
   );

   always_comb begin
      state_d   = state_q;
      prog_d    = prog_q;
      len_d     = len_q;
      node_d    = node_q;
      pat_d     = pat_q;
      nodeVal_d = nodeVal_q;
      ttData_d  = ttData_q;
      ttIdx_d   = ttIdx_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_we) begin
               prog_d[cfg_addr] = node_cfg_t'(cfg_data);
            end
            if (len_we) begin
               len_d = len_data;
            end
            if (start) begin
               state_d   = ST_EVAL;
               node_d    = '0;
               pat_d     = '0;
               nodeVal_d = '0;
            end
         end
         ST_EVAL: begin
            // The last program node is the function output for this pattern.
            if (node_q == len_q) begin
               ttData_d[pat_q[4:0]] = majOut;
               nodeVal_d = '0;
               node_d    = '0;
               pat_d     = pat_q + 7'd1;
               if (pat_q[4:0] == 5'd31) begin
                  state_d = ST_EMIT;
                  ttIdx_d = pat_q[6:5];
               end
            end else begin
               nodeVal_d[node_q] = majOut;
               node_d            = node_q + 3'd1;
            end
         end
         ST_EMIT: begin
            if (tt_ready) begin
               if (ttIdx_q == 2'd3) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_EVAL;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         prog_q    <= {NODES{NODE_RESET}};
         len_q     <= '0;
         node_q    <= '0;
         pat_q     <= '0;
         nodeVal_q <= '0;
         ttData_q  <= '0;
         ttIdx_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prog_q    <= prog_d;
         len_q     <= len_d;
         node_q    <= node_d;
         pat_q     <= pat_d;
         nodeVal_q <= nodeVal_d;
         ttData_q  <= ttData_d;
         ttIdx_q   <= ttIdx_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign tt_valid = (state_q == ST_EMIT);
   assign tt_data  = ttData_q;
   assign tt_idx   = ttIdx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Directed-vector bench for maj_net_sequencer with hand-computed truth tables.
module tb_maj_net_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [11:0] cfg_data;
   logic        len_we;
   logic [2:0]  len_data;
   logic        start;
   logic        busy;
   logic        done;
   logic        tt_valid;
   logic        tt_ready;
   logic [31:0] tt_data;
   logic [1:0]  tt_idx;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   maj_net_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .len_we   (len_we),
      .len_data (len_data),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .tt_valid (tt_valid),
      .tt_ready (tt_ready),
      .tt_data  (tt_data),
      .tt_idx   (tt_idx)
   );

   task automatic writeNode(input logic [2:0] addr, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] c);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = {c, b, a};
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic writeLen(input logic [2:0] lenM1);
      len_we   = 1'b1;
      len_data = lenM1;
      @(negedge clk);
      len_we   = 1'b0;
   endtask

   // Starts a sweep and collects four words; latencies are counted in
   // negedges after the edge that samples start.
   task automatic runSweep(input int stallWord, input int stallCycles, input bit injectBusy,
                           output logic [127:0] words, output logic [7:0] idxs,
                           output int firstLat, output int total, output bit timedOut,
                           output bit doneOk, output bit stallOk);
      int cyc;
      int w;
      int held;
      logic [31:0] seenData;
      logic [1:0]  seenIdx;
      cyc = 0; w = 0; held = 0;
      words = '0; idxs = '0; firstLat = 0; total = 0;
      timedOut = 1'b0; doneOk = 1'b0; stallOk = 1'b1;
      seenData = '0; seenIdx = '0;
      start    = 1'b1;
      tt_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0; len_we = 1'b0;
      cyc = 1;
      while (w < 4 && !timedOut) begin
         if (injectBusy && cyc == 10) begin
            cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 12'h777;
            len_we = 1'b1; len_data = 3'd2; start = 1'b1;
         end else begin
            cfg_we = 1'b0; len_we = 1'b0; start = 1'b0;
         end
         if (tt_valid === 1'b1) begin
            if (w == 0 && firstLat == 0) firstLat = cyc;
            if (w == stallWord && held < stallCycles) begin
               if (held == 0) begin
                  seenData = tt_data;
                  seenIdx  = tt_idx;
               end else if (tt_data !== seenData || tt_idx !== seenIdx) begin
                  stallOk = 1'b0;
               end
               if (busy !== 1'b1) stallOk = 1'b0;
               held++;
               tt_ready = 1'b0;
            end else begin
               words[w*32 +: 32] = tt_data;
               idxs[w*2 +: 2]    = tt_idx;
               w++;
               tt_ready = 1'b1;
            end
         end
         if (w < 4) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) timedOut = 1'b1;
         end
      end
      cfg_we = 1'b0; len_we = 1'b0; start = 1'b0;
      if (!timedOut) begin
         @(negedge clk);
         cyc++;
         doneOk = (done === 1'b1 && busy === 1'b0 && tt_valid === 1'b0);
         @(negedge clk);
         if (done !== 1'b0) doneOk = 1'b0;
      end
      total = cyc;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      nChecks++; if (tt_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b expected 0", tt_valid); end
      nChecks++; if (tt_data !== 32'h0) begin nFail++; $display("[TB] FAIL reset_data: got %h expected 00000000", tt_data); end
      nChecks++; if (tt_idx !== 2'd0) begin nFail++; $display("[TB] FAIL reset_idx: got %0d expected 0", tt_idx); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_maj3;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      logic [1:0] expIdx;
      writeNode(3'd0, 4'd0, 4'd1, 4'd2);
      writeLen(3'd0);
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      nChecks++; if (timedOut !== 1'b0) begin nFail++; $display("[TB] FAIL maj3_timeout: got %b expected 0", timedOut); end
      for (int i = 0; i < 4; i++) begin
         expIdx = 2'(i);
         nChecks++; if (words[i*32 +: 32] !== 32'hE8E8E8E8) begin nFail++; $display("[TB] FAIL maj3_word%0d: got %h expected e8e8e8e8", i, words[i*32 +: 32]); end
         nChecks++; if (idxs[i*2 +: 2] !== expIdx) begin nFail++; $display("[TB] FAIL maj3_idx%0d: got %0d expected %0d", i, idxs[i*2 +: 2], expIdx); end
      end
      nChecks++; if (firstLat !== 33) begin nFail++; $display("[TB] FAIL maj3_first_latency: got %0d expected 33", firstLat); end
      nChecks++; if (total !== 133) begin nFail++; $display("[TB] FAIL maj3_total: got %0d expected 133", total); end
      nChecks++; if (doneOk !== 1'b1) begin nFail++; $display("[TB] FAIL maj3_done_pulse: got %b expected 1", doneOk); end
   endtask

   task automatic test_and_x6;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      logic [127:0] expX6;
      writeNode(3'd0, 4'd0, 4'd1, 4'd7);
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (words[i*32 +: 32] !== 32'h88888888) begin nFail++; $display("[TB] FAIL and_word%0d: got %h expected 88888888", i, words[i*32 +: 32]); end
      end
      expX6 = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      writeNode(3'd0, 4'd6, 4'd6, 4'd6);
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (words[i*32 +: 32] !== expX6[i*32 +: 32]) begin nFail++; $display("[TB] FAIL x6_word%0d: got %h expected %h", i, words[i*32 +: 32], expX6[i*32 +: 32]); end
      end
      nChecks++; if (doneOk !== 1'b1) begin nFail++; $display("[TB] FAIL x6_done_pulse: got %b expected 1", doneOk); end
   endtask

   task automatic test_forward_ref;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      writeNode(3'd0, 4'd9, 4'd9, 4'd9);
      writeNode(3'd1, 4'd0, 4'd0, 4'd0);
      writeLen(3'd1);
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (words[i*32 +: 32] !== 32'hAAAAAAAA) begin nFail++; $display("[TB] FAIL fwd_word%0d: got %h expected aaaaaaaa", i, words[i*32 +: 32]); end
      end
      nChecks++; if (firstLat !== 65) begin nFail++; $display("[TB] FAIL fwd_first_latency: got %0d expected 65", firstLat); end
      nChecks++; if (total !== 261) begin nFail++; $display("[TB] FAIL fwd_total: got %0d expected 261", total); end
   endtask

   task automatic test_stall;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      writeNode(3'd0, 4'd0, 4'd1, 4'd2);
      writeLen(3'd0);
      runSweep(1, 10, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      nChecks++; if (stallOk !== 1'b1) begin nFail++; $display("[TB] FAIL stall_stable: got %b expected 1", stallOk); end
      nChecks++; if (words[63:32] !== 32'hE8E8E8E8) begin nFail++; $display("[TB] FAIL stall_word1: got %h expected e8e8e8e8", words[63:32]); end
      nChecks++; if (idxs[3:2] !== 2'd1) begin nFail++; $display("[TB] FAIL stall_idx1: got %0d expected 1", idxs[3:2]); end
      nChecks++; if (total !== 143) begin nFail++; $display("[TB] FAIL stall_total: got %0d expected 143", total); end
   endtask

   task automatic test_reset_abort;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      bit quiet;
      writeNode(3'd1, 4'd8, 4'd1, 4'd2);
      writeNode(3'd2, 4'd9, 4'd0, 4'd3);
      writeLen(3'd2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      nChecks++; if (tt_valid !== 1'b0) begin nFail++; $display("[TB] FAIL abort_valid: got %b expected 0", tt_valid); end
      quiet = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (tt_valid !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      nChecks++; if (quiet !== 1'b1) begin nFail++; $display("[TB] FAIL abort_quiet: got %b expected 1", quiet); end
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (words[i*32 +: 32] !== 32'h00000000) begin nFail++; $display("[TB] FAIL abort_word%0d: got %h expected 00000000", i, words[i*32 +: 32]); end
      end
      nChecks++; if (firstLat !== 33) begin nFail++; $display("[TB] FAIL abort_first_latency: got %0d expected 33", firstLat); end
   endtask

   task automatic test_busy_writes;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      writeNode(3'd0, 4'd0, 4'd1, 4'd2);
      writeLen(3'd0);
      runSweep(-1, 0, 1'b1, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      nChecks++; if (words[127:96] !== 32'hE8E8E8E8) begin nFail++; $display("[TB] FAIL busy_inject_word3: got %h expected e8e8e8e8", words[127:96]); end
      nChecks++; if (total !== 133) begin nFail++; $display("[TB] FAIL busy_inject_total: got %0d expected 133", total); end
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (words[i*32 +: 32] !== 32'hE8E8E8E8) begin nFail++; $display("[TB] FAIL busy_after_word%0d: got %h expected e8e8e8e8", i, words[i*32 +: 32]); end
      end
      nChecks++; if (firstLat !== 33) begin nFail++; $display("[TB] FAIL busy_after_latency: got %0d expected 33", firstLat); end
   endtask

   task automatic test_cfg_with_start;
      logic [127:0] words; logic [7:0] idxs;
      int firstLat, total; bit timedOut, doneOk, stallOk;
      logic [127:0] expX6;
      expX6 = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      cfg_we   = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = {4'd6, 4'd6, 4'd6};
      runSweep(-1, 0, 1'b0, words, idxs, firstLat, total, timedOut, doneOk, stallOk);
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (words[i*32 +: 32] !== expX6[i*32 +: 32]) begin nFail++; $display("[TB] FAIL cfgstart_word%0d: got %h expected %h", i, words[i*32 +: 32], expX6[i*32 +: 32]); end
      end
      nChecks++; if (timedOut !== 1'b0) begin nFail++; $display("[TB] FAIL cfgstart_timeout: got %b expected 0", timedOut); end
   endtask

   initial begin
      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_addr = 3'd0;
      cfg_data = 12'h0;
      len_we   = 1'b0;
      len_data = 3'd0;
      start    = 1'b0;
      tt_ready = 1'b0;
      test_reset;
      test_maj3;
      test_and_x6;
      test_forward_ref;
      test_stall;
      test_reset_abort;
      test_busy_writes;
      test_cfg_with_start;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/maj_net_sequencer.md
MAJ_NET_SEQUENCER -- requirements
Module: maj_net_sequencer

Interface
REQ-001 Clocking and reset SHALL be one clock `clk` with reset `rst`, synchronous and active-high.
REQ-002 Parameter NODES, default 8, SHALL set program depth; it is fixed by the 4-bit select encoding.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cfg_we  in  1  write program node cfg_addr with cfg_data.
REQ-006 cfg_addr  in  3  node index 0..7.
REQ-007 cfg_data  in  12  operand selects {sel_c[11:8], sel_b[7:4], sel_a[3:0]}.
REQ-008 len_we  in  1  write program length register.
REQ-009 len_data  in  3  program length minus one; L = len_data + 1.
REQ-010 start  in  1  request full truth-table sweep.
REQ-011 busy  out  1  sweep in progress.
REQ-012 done  out  1  one-cycle pulse at sweep completion.
REQ-013 tt_valid  out  1  truth-table word available.
REQ-014 tt_ready  in  1  consumer accepts word.
REQ-015 tt_data  out  32  truth-table word.
REQ-016 tt_idx  out  2  word index 0..3.

Function
REQ-017 Select encoding SHALL be: 0..6 = x0..x6 of the current pattern; 7 = constant 0; 8..15 = node_val[sel-8].
- Each node SHALL compute MAJ(a,b,c) through one shared MAJ3 unit.
- Exactly one node SHALL be evaluated per cycle.
REQ-018 Pattern p SHALL range over 0..127, with xi = p[i].
- Nodes 0..L-1 SHALL be evaluated in order.
- Function result SHALL be node L-1.
REQ-019 node_val SHALL clear to 0 at the start of each pattern.
- A reference to node k >= current node SHALL read 0.
REQ-020 States SHALL be IDLE, EVAL, EMIT, with these transitions:
- IDLE->EVAL on start.
- EVAL->EMIT after the last node of a pattern with p[4:0]==31.
- EMIT->EVAL on handshake when tt_idx<3.
- EMIT->IDLE on handshake when tt_idx==3.
REQ-021 Result bit of pattern p SHALL be placed at tt_data[p[4:0]] of word p[6:5].
REQ-022 tt_valid SHALL be asserted only in EMIT.
- tt_data and tt_idx SHALL be held stable until the cycle where tt_valid & tt_ready.
- Evaluation SHALL stall while in EMIT.
REQ-023 If start is sampled in IDLE at edge t, the first tt_valid SHALL be seen in cycle t+32·L+1.
- With tt_ready held high, each subsequent word SHALL follow 32·L+1 cycles after the previous handshake.
REQ-024 done SHALL pulse in the cycle after the word-3 handshake, coinciding with return to IDLE.
REQ-025 busy SHALL be 1 in EVAL and EMIT.
REQ-026 start while busy SHALL be ignored.
REQ-027 cfg_we and len_we while busy SHALL be ignored, leaving the program unchanged mid-sweep.
REQ-028 cfg_we and start in the same IDLE cycle SHALL both take effect, and the write SHALL be visible to the sweep.

Reset
REQ-029 On rst, the following SHALL be forced:
- state = IDLE.
- busy, done, tt_valid = 0.
- tt_data = 0, tt_idx = 0.
- All program selects = 7 (constant 0), len = 0, node_val = 0.
REQ-030 rst during EVAL or EMIT SHALL abort the sweep immediately.
- No further tt_valid or done SHALL occur.

Structure
REQ-031 Package maj_seq_pkg SHALL hold:
- the state enum;
- select constants (SEL_X0..SEL_X6, SEL_ZERO=7, SEL_NODE_BASE=8);
- NODES=8, WORD_W=32, PATTERNS=128.
REQ-032 The MAJ3 function SHALL be a sub-module maj3_cell, instantiated exactly once.

Verification
REQ-033 Program node0=MAJ(x0,x1,x2), L=1, tt_ready=1 -> four words 0xE8E8E8E8, tt_idx 0..3, done one cycle after last handshake.
REQ-034 Program node0=MAJ(x0,x1,const0), L=1 -> all words 0x88888888.
- Then node0=MAJ(x6,x6,x6) -> words 0x00000000, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFF.
REQ-035 Program node0 selects node1 (forward reference), node1=MAJ(x0,x0,x0), L=2, output node1 -> words 0xAAAAAAAA; node0 contributes 0.
REQ-036 Stall: hold tt_ready=0 for 10 cycles on word 1 -> tt_data/tt_idx stable, busy=1, total sweep length grows by exactly 10 cycles.
REQ-037 Assert rst at cycle 50 of an L=3 sweep -> busy=0, tt_valid=0 next cycle.
- A start after reset -> four words 0x00000000, from the reset program with L=1.
REQ-038 cfg_we pulsed while busy -> ignored; the following sweep reproduces the original program's words.
